// File: rtl/div_sequencer.sv
// Sequencer around the combinational restoring divider array.
// Captures magnitudes, waits for the array to settle, then sign-corrects into HI/LO.
module div_sequencer #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        start,
   input  logic        signed_op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic [31:0] div_q_out,
   output logic [31:0] div_m_out,
   input  logic [31:0] div_quot_in,
   input  logic [31:0] div_rem_in,
   output logic        busy,
   output logic        done,
   output logic        div_by_zero,
   output logic [31:0] HI_out,
   output logic [31:0] LO_out
);

   localparam int CW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      WRITE
   } state_t;

   state_t          state, state_nx;
   logic [CW-1:0]   cnt;
   logic            neg_q, neg_r, byp, zdiv;
   logic            accept, last;
   logic            neg_a, neg_b;
   logic [31:0]     amag, bmag;
   logic [31:0]     raw_q, raw_r;
   logic [31:0]     lo_nx, hi_nx;
   logic            ge;

   assign accept = (state == IDLE) && start;
   assign last   = (state == WAIT) && (cnt == '0);
   assign busy   = (state != IDLE);
   assign done   = (state == WRITE);

   assign neg_a = signed_op & dividend[31];
   assign neg_b = signed_op & divisor[31];
   assign amag  = neg_a ? -dividend : dividend;
   assign bmag  = neg_b ? -divisor : divisor;

   // the array cannot handle a divisor of 2^31 or more; one compare suffices
   always_comb begin
      ge    = (div_q_out >= div_m_out);
      raw_q = div_quot_in;
      raw_r = div_rem_in;
      if (byp) begin
         raw_q = {31'b0, ge};
         raw_r = ge ? (div_q_out - div_m_out) : div_q_out;
      end
      lo_nx = neg_q ? -raw_q : raw_q;
      hi_nx = neg_r ? -raw_r : raw_r;
      if (zdiv) begin
         lo_nx = 32'hFFFF_FFFF;
         hi_nx = neg_r ? -div_q_out : div_q_out;
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start) state_nx = WAIT;
         WAIT:    if (cnt == '0) state_nx = WRITE;
         WRITE:   state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         cnt         <= '0;
         div_q_out   <= '0;
         div_m_out   <= '0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         byp         <= 1'b0;
         zdiv        <= 1'b0;
         div_by_zero <= 1'b0;
         HI_out      <= '0;
         LO_out      <= '0;
      end else begin
         if (accept) begin
            cnt         <= CW'(SETTLE_CYCLES);
            div_q_out   <= amag;
            div_m_out   <= bmag;
            neg_q       <= signed_op & (dividend[31] ^ divisor[31]);
            neg_r       <= neg_a;
            byp         <= (divisor == '0) | bmag[31];
            zdiv        <= (divisor == '0);
            div_by_zero <= 1'b0;
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - CW'(1);
         end
         if (last) begin
            LO_out      <= lo_nx;
            HI_out      <= hi_nx;
            div_by_zero <= zdiv;
         end
      end
   end

endmodule
